// File: rtl/mem_serializer_if.sv
// ROM-side bus and serial-output bundle for mem_serializer.
interface mem_serializer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              tx_bit;
    logic              bit_strobe;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_data,
        output mem_addr, tx_bit, bit_strobe, busy, done
    );

    modport slave (
        output start, mem_data,
        input  mem_addr, tx_bit, bit_strobe, busy, done
    );
endinterface

// File: rtl/mem_serializer.sv
// Walks the ROM from address 0 to DEPTH-1, latching each word and shifting
// it out MSB first, each bit held for BIT_DIV clocks. Moore outputs only.
module mem_serializer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 6,
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    mem_serializer_if.master bus
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    // State and datapath registers, synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FETCH;
                    word_cnt_d = '0;
                end
            end
            FETCH: begin
                shreg_d   = bus.mem_data;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt_q < DIV_LAST) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else if (bit_cnt_q < BIT_LAST) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    div_cnt_d = '0;
                end else if (word_cnt_q == WORD_LAST) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = FETCH;
                end
            end
            DONE: begin
                word_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        bus.mem_addr   = '0;
        bus.tx_bit     = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_addr = word_cnt_q;
                bus.busy     = 1'b1;
            end
            SHIFT: begin
                bus.mem_addr   = word_cnt_q;
                bus.busy       = 1'b1;
                bus.tx_bit     = shreg_q[DATA_W-1];
                bus.bit_strobe = (div_cnt_q == '0);
            end
            DONE: begin
                bus.mem_addr = word_cnt_q;
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_serializer.sv
// Scoreboard bench for mem_serializer: instance 0 uses defaults, instance 1
// uses BIT_DIV=1, DEPTH=2. Stimulus pushes expected events, a negedge
// monitor pops and compares them.
module tb_mem_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rom [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'h00, 8'h00};

    mem_serializer_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
    mem_serializer_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

    assign bus0.mem_data = rom[bus0.mem_addr];
    assign bus1.mem_data = rom[bus1.mem_addr];

    mem_serializer #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .BIT_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    mem_serializer #(.DATA_W(8), .ADDR_W(3), .DEPTH(2), .BIT_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        int         cyc;
        logic       tx;
        logic [2:0] addr;
    } strobe_t;

    strobe_t    sq      [2][$];
    int         rise_q  [2][$];
    int         fall_q  [2][$];
    int         done_q  [2][$];
    logic [7:0] byte_q  [2][$];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;

    int         div_of    [2] = '{4, 1};
    int         last_sc   [2] = '{-100, -100};
    logic       last_tx   [2] = '{1'b0, 1'b0};
    logic       prev_busy [2] = '{1'b0, 1'b0};
    logic [7:0] asm_byte  [2] = '{8'h00, 8'h00};
    int         asm_n     [2] = '{0, 0};
    int         n_strobe  [2] = '{0, 0};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_msg(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event required none (cycle %0d)", name, cyc);
    endfunction

    function automatic void observe(int i, logic busy, logic done, logic strobe,
                                    logic tx, logic [2:0] addr);
        strobe_t e;
        if (busy !== prev_busy[i]) begin
            if (busy === 1'b1) begin
                if (rise_q[i].size() == 0) fail_msg($sformatf("busy_rise%0d", i));
                else chk($sformatf("busy_rise%0d", i), cyc, rise_q[i].pop_front());
            end else begin
                if (fall_q[i].size() == 0) fail_msg($sformatf("busy_fall%0d", i));
                else chk($sformatf("busy_fall%0d", i), cyc, fall_q[i].pop_front());
            end
        end
        prev_busy[i] = busy;

        if (done === 1'b1) begin
            if (done_q[i].size() == 0) fail_msg($sformatf("done%0d", i));
            else chk($sformatf("done_cycle%0d", i), cyc, done_q[i].pop_front());
        end

        if (strobe === 1'b1) begin
            n_strobe[i]++;
            if (sq[i].size() == 0) begin
                fail_msg($sformatf("strobe%0d", i));
            end else begin
                e = sq[i].pop_front();
                chk($sformatf("strobe_cycle%0d", i), cyc, e.cyc);
                chk($sformatf("strobe_tx%0d", i), tx, e.tx);
                chk($sformatf("strobe_addr%0d", i), addr, e.addr);
            end
            last_sc[i]  = cyc;
            last_tx[i]  = tx;
            asm_byte[i] = {asm_byte[i][6:0], tx};
            asm_n[i]++;
            if (asm_n[i] == 8) begin
                asm_n[i] = 0;
                if (byte_q[i].size() == 0) fail_msg($sformatf("byte%0d", i));
                else chk($sformatf("byte%0d", i), asm_byte[i], byte_q[i].pop_front());
            end
        end else if (busy === 1'b1 && done !== 1'b1) begin
            if (cyc - last_sc[i] < div_of[i]) chk($sformatf("tx_hold%0d", i), tx, last_tx[i]);
            else chk($sformatf("tx_fetch%0d", i), tx, 0);
        end else begin
            chk($sformatf("tx_idle%0d", i), tx, 0);
            if (busy !== 1'b1) chk($sformatf("addr_idle%0d", i), addr, 0);
        end

        if (rst === 1'b1) asm_n[i] = 0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            observe(0, bus0.busy, bus0.done, bus0.bit_strobe, bus0.tx_bit, bus0.mem_addr);
            observe(1, bus1.busy, bus1.done, bus1.bit_strobe, bus1.tx_bit, bus1.mem_addr);
        end
    end

    // Expected events for one frame whose start is sampled in cycle c0.
    task automatic issue_frame(input int i, input int c0, input int depth);
        strobe_t e;
        int      d;
        int      done_c;
        d      = div_of[i];
        done_c = c0 + 1 + depth * (1 + 8 * d);
        rise_q[i].push_back(c0 + 1);
        for (int w = 0; w < depth; w++) begin
            byte_q[i].push_back(rom[w]);
            for (int b = 0; b < 8; b++) begin
                e.cyc  = c0 + 2 + w * (1 + 8 * d) + b * d;
                e.tx   = rom[w][7-b];
                e.addr = w[2:0];
                sq[i].push_back(e);
            end
        end
        done_q[i].push_back(done_c);
        fall_q[i].push_back(done_c + 1);
    endtask

    task automatic set_start(input int i, input logic v);
        if (i == 0) bus0.start = v;
        else bus1.start = v;
    endtask

    task automatic start_frame(input int i, input int depth, output int c0);
        @(posedge clk); #1;
        c0 = cyc;
        issue_frame(i, c0, depth);
        set_start(i, 1'b1);
        @(posedge clk); #1;
        set_start(i, 1'b0);
    endtask

    task automatic wait_idle(input int i, input int max_cyc);
        int n;
        n = 0;
        while ((done_q[i].size() != 0 || fall_q[i].size() != 0) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= max_cyc) fail_msg($sformatf("timeout%0d", i));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    int c0;
    int c1;

    initial begin
        // Reset with start held high: nothing may begin.
        rst        = 1'b1;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("rst_busy", bus0.busy, 0);
        chk("rst_tx", bus0.tx_bit, 0);
        chk("rst_strobe", bus0.bit_strobe, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_addr", bus0.mem_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_end", bus0.busy, 0);
        rst        = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);

        // Full default frame and strobe count.
        n_strobe[0] = 0;
        start_frame(0, 6, c0);
        chk("fetch0_addr", bus0.mem_addr, 0);
        chk("fetch0_busy", bus0.busy, 1);
        wait_idle(0, 300);
        chk("strobe_count", n_strobe[0], 48);

        // Start toggled while busy must be ignored.
        n_strobe[0] = 0;
        start_frame(0, 6, c0);
        wait_until(c0 + 5);
        for (int k = 5; k <= 150; k++) begin
            bus0.start = ~k[0];
            @(posedge clk); #1;
        end
        bus0.start = 1'b0;
        wait_idle(0, 300);
        chk("busy_strobe_count", n_strobe[0], 48);

        // Reset in word 2, then restart from address 0.
        start_frame(0, 6, c0);
        wait_until(c0 + 80);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sq[0].delete();
        byte_q[0].delete();
        done_q[0].delete();
        fall_q[0].delete();
        fall_q[0].push_back(c0 + 81);
        chk("abort_busy", bus0.busy, 0);
        chk("abort_tx", bus0.tx_bit, 0);
        wait_until(c0 + 84);
        start_frame(0, 6, c1);
        chk("restart_cycle", c1, c0 + 85);
        chk("restart_addr", bus0.mem_addr, 0);
        chk("restart_busy", bus0.busy, 1);
        wait_idle(0, 300);

        // BIT_DIV=1, DEPTH=2 instance.
        n_strobe[1] = 0;
        start_frame(1, 2, c0);
        wait_idle(1, 100);
        chk("div1_strobe_count", n_strobe[1], 16);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("left_strobes%0d", i), sq[i].size(), 0);
            chk($sformatf("left_done%0d", i), done_q[i].size(), 0);
            chk($sformatf("left_rise%0d", i), rise_q[i].size(), 0);
            chk($sformatf("left_bytes%0d", i), byte_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_serializer.md
# mem_serializer

Sequencer and parallel-to-serial converter directly downstream of the `testMem` ROM. It drives the ROM address, captures each 8-bit word, and shifts it out MSB-first at a programmable bit rate. It produces a contiguous bit stream of all DEPTH words for the transmit path of the digital communications chain.

## Interface
- `DATA_W`, default 8: ROM word width in bits.
- `ADDR_W`, default 3: ROM address width in bits.
- `DEPTH`, default 6: number of words sent per frame, addresses 0..DEPTH-1.
  - Constraint: 1 ≤ DEPTH ≤ 2^ADDR_W.
- `BIT_DIV`, default 4: clock cycles each bit is held on `tx_bit`.
  - Constraint: BIT_DIV ≥ 1.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: frame request, sampled only in IDLE.
- `mem_addr`  out  ADDR_W: address to the ROM.
- `mem_data`  in  DATA_W: ROM output, combinational from `mem_addr`.
- `tx_bit`  out  1: serial data, MSB first.
- `bit_strobe`  out  1: high in the first cycle of each new bit.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle pulse at frame end.

## Operation
- The FSM has four states: IDLE, FETCH, SHIFT, DONE.
- Internal registers:
  - `word_cnt` (ADDR_W bits)
  - `bit_cnt` (clog2(DATA_W) bits)
  - `div_cnt` (max(1, clog2(BIT_DIV)) bits)
  - `shreg` (DATA_W bits)
- IDLE:
  - `mem_addr`=0, `busy`=0.
  - `start`=1 → FETCH, with `word_cnt`=0.
- FETCH:
  - `mem_addr`=`word_cnt`, `busy`=1.
  - At the clock edge: `shreg`←`mem_data`, `bit_cnt`←0, `div_cnt`←0, → SHIFT.
- SHIFT:
  - `tx_bit`=`shreg[DATA_W-1]`; `bit_strobe`=(`div_cnt`==0).
  - `div_cnt`<BIT_DIV-1: `div_cnt`++.
  - `div_cnt`==BIT_DIV-1 and `bit_cnt`<DATA_W-1: `shreg`←`shreg`<<1, `bit_cnt`++, `div_cnt`←0.
  - `div_cnt`==BIT_DIV-1 and `bit_cnt`==DATA_W-1:
    - If `word_cnt`==DEPTH-1 → DONE.
    - Otherwise `word_cnt`++ → FETCH.
- DONE:
  - `done`=1, `busy`=1.
  - → IDLE, `word_cnt`←0.
- `mem_addr` equals `word_cnt` in FETCH, SHIFT and DONE, and is 0 in IDLE. It never exceeds DEPTH-1, so the address never wraps.
- `tx_bit`=0 and `bit_strobe`=0 outside SHIFT.
- `start` is ignored in FETCH, SHIFT and DONE. No request is queued.
- All outputs decode from registered state (Moore); no output depends combinationally on `start` or `mem_data`.

## Timing
- Reset:
  - When `rst`=1 at an edge, the FSM enters IDLE and every counter and `shreg` clears.
  - Outputs after reset: `mem_addr`=0, `tx_bit`=0, `bit_strobe`=0, `busy`=0, `done`=0.
  - `rst` has priority over `start`, including when both are asserted in the same cycle.
  - Reset mid-frame aborts immediately. A new frame restarts from address 0.
- Cycle numbering: cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
  - Cycle 1: FETCH, `busy`=1, `mem_addr`=0.
  - First bit (word 0 MSB) appears in cycle 2, with `bit_strobe`=1.
- Word w:
  - FETCH occurs in cycle 1+w·(1+DATA_W·BIT_DIV).
  - Its bits follow in the next DATA_W·BIT_DIV cycles.
  - There is one idle-bit (FETCH) cycle between words, with `tx_bit`=0.
- DONE occurs in cycle 1+DEPTH·(1+DATA_W·BIT_DIV).
  - With defaults this is cycle 199; `busy` returns to 0 in cycle 200.
- The earliest next frame: `start` sampled in cycle 200 gives FETCH in cycle 201.
- BIT_DIV=1: `bit_strobe` is high for every SHIFT cycle and each bit lasts exactly one cycle.
- `mem_data` must be stable during the FETCH cycle. The ROM is combinational, so there is zero wait.

## Test plan
1. **Reset values.** Bench ROM model contents 0xA5,0x3C,0xFF,0x00,0x81,0x5A. Assert `rst` for 3 cycles with `start`=1. Required: all outputs 0, `busy` stays 0 throughout.
2. **Full frame, defaults.** Pulse `start` in cycle 0. Required:
   - `mem_addr` sequences 0..5 at cycles 1, 34, 67, 100, 133, 166.
   - `tx_bit` holds 1,0,1,0,0,1,0,1 in 4-cycle groups from cycle 2.
   - `done` is high only in cycle 199.
   - Recovered bytes match the ROM.
3. **Strobe count.** Same frame as scenario 2. Required: exactly 48 `bit_strobe` pulses, spaced 4 cycles apart within a word and 5 cycles apart across the word boundary.
4. **Start while busy.** Toggle `start` every cycle from cycle 5 to 150. Required: timing identical to scenario 2, and no second frame begins before cycle 200.
5. **Mid-frame reset.** Assert `rst` in cycle 80 (word 2). Required: `busy`=0 and `tx_bit`=0 in cycle 81. A `start` in cycle 85 gives `mem_addr`=0 in cycle 86.
6. **BIT_DIV=1, DEPTH=2.** Run one frame. Required:
   - FETCH in cycles 1 and 10.
   - Bits of 0xA5 in cycles 2–9.
   - Bits of 0x3C in cycles 11–18.
   - `done` in cycle 19.
